// File: rtl/apb0_pkg.sv
// Shared definitions for the APB0 root decoder slice.
//   wd_state_t   : watchdog FSM states, one-hot encoded
//   APB0_SLOT_W  : log2 of the peripheral window size (4 KB windows)
//   APB0_SLV_MAX : largest supported number of peripheral slots
package apb0_pkg;

  typedef enum logic [2:0] {
    WD_IDLE   = 3'b001,
    WD_ACCESS = 3'b010,
    WD_TOUT   = 3'b100
  } wd_state_t;

  localparam int APB0_SLOT_W  = 12;
  localparam int APB0_SLV_MAX = 16;

endpackage

// File: rtl/apb0_slv_mux.sv
// Combinational select / response mux for the APB0 root decoder.
// Ports:
//   idx, hit        : decoded slot index and decode-hit flag
//   tout_flag       : watchdog has aborted the current transfer
//   psel, penable   : root bus control from the bridge
//   slv_pready/pslverr/prdata : per-slot responses (slot n data at [32n+31:32n])
//   slv_psel, slv_penable     : one-hot peripheral select and shared penable
//   sel_pready      : raw pready of the decoded slot (watchdog input)
//   root_pready/pslverr/prdata: response returned to the bridge
module apb0_slv_mux #(
  parameter int SLV_NUM = 8
) (
  input  logic [3:0]           idx,
  input  logic                 hit,
  input  logic                 tout_flag,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [SLV_NUM-1:0]   slv_pready,
  input  logic [SLV_NUM-1:0]   slv_pslverr,
  input  logic [32*SLV_NUM-1:0] slv_prdata,
  output logic [SLV_NUM-1:0]   slv_psel,
  output logic                 slv_penable,
  output logic                 sel_pready,
  output logic                 root_pready,
  output logic                 root_pslverr,
  output logic [31:0]          root_prdata
);

  logic        sel_pslverr;
  logic [31:0] sel_prdata;

  always_comb begin
    slv_psel    = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    // Only the decoded slot contributes, so an unselected slot's pslverr
    // can never leak onto the root bus.
    for (int n = 0; n < SLV_NUM; n++) begin
      if (hit && (idx == 4'(n))) begin
        slv_psel[n] = psel & ~tout_flag;
        sel_pready  = slv_pready[n];
        sel_pslverr = slv_pslverr[n];
        sel_prdata  = slv_prdata[32*n +: 32];
      end
    end
    slv_penable = penable & hit & ~tout_flag;

    root_pready  = 1'b0;
    root_pslverr = 1'b0;
    root_prdata  = '0;
    if (tout_flag) begin
      // Aborted transfer: complete it with an error.
      root_pready  = 1'b1;
      root_pslverr = 1'b1;
    end else if (!hit && psel && penable) begin
      // Default slave for unmapped addresses, zero wait states.
      root_pready  = 1'b1;
      root_pslverr = 1'b1;
    end else if (hit) begin
      root_pready  = sel_pready;
      root_pslverr = sel_pslverr;
      root_prdata  = sel_prdata;
    end
  end

endmodule

// File: rtl/apb0_root_decoder.sv
// APB0 root decoder: decodes the bridge's root APB bus onto SLV_NUM
// peripheral slots (4 KB windows under BASE_HI), muxes the responses back,
// acts as an error-returning default slave, and aborts hung peripherals
// with an access-phase watchdog.
// Ports:
//   i_hclk, i_hrst_n (async active-low), i_pclk_en (APB clock enable)
//   i_root_*   : bridge request; o_root_* : response to the bridge
//   o_slv_*    : shared/one-hot request to peripherals; i_slv_* : responses
//   o_tout_pulse : one-hclk pulse when the watchdog fires
//   o_tout_idx   : slot of the last timeout, held until the next one
//   o_wd_state   : current watchdog FSM state (debug visibility)
// Handshake: a transfer completes on an i_hclk edge with i_pclk_en=1 while
// psel & penable & pready are all high; wait states are pclk-enabled
// access cycles with pready low.
module apb0_root_decoder
  import apb0_pkg::*;
#(
  parameter logic [15:0] BASE_HI = 16'h4001,
  parameter int          SLV_NUM = 8,
  parameter int          TIMEOUT = 255
) (
  input  logic                  i_hclk,
  input  logic                  i_hrst_n,
  input  logic                  i_pclk_en,
  input  logic                  i_root_psel,
  input  logic                  i_root_penable,
  input  logic [31:0]           i_root_paddr,
  input  logic                  i_root_pwrite,
  input  logic [31:0]           i_root_pwdata,
  input  logic [3:0]            i_root_pstrb,
  input  logic [2:0]            i_root_pprot,
  output logic                  o_root_pready,
  output logic                  o_root_pslverr,
  output logic [31:0]           o_root_prdata,
  output logic [SLV_NUM-1:0]    o_slv_psel,
  output logic                  o_slv_penable,
  output logic [31:0]           o_slv_paddr,
  output logic                  o_slv_pwrite,
  output logic [31:0]           o_slv_pwdata,
  output logic [3:0]            o_slv_pstrb,
  output logic [2:0]            o_slv_pprot,
  input  logic [SLV_NUM-1:0]    i_slv_pready,
  input  logic [SLV_NUM-1:0]    i_slv_pslverr,
  input  logic [32*SLV_NUM-1:0] i_slv_prdata,
  output logic                  o_tout_pulse,
  output logic [3:0]            o_tout_idx,
  output logic [2:0]            o_wd_state
);

  // A zero TIMEOUT still needs a legal (1-bit) counter.
  localparam int             CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [3:0]       idx;
  logic             hit;
  logic             tout_flag;
  logic             sel_pready;
  logic             fire;
  wd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign idx = i_root_paddr[APB0_SLOT_W +: 4];
  assign hit = (i_root_paddr[31:16] == BASE_HI) && ({28'd0, idx} < 32'(SLV_NUM));

  assign tout_flag  = (state_q == WD_TOUT);
  assign o_wd_state = state_q;

  assign o_slv_paddr  = i_root_paddr;
  assign o_slv_pwrite = i_root_pwrite;
  assign o_slv_pwdata = i_root_pwdata;
  assign o_slv_pstrb  = i_root_pstrb;
  assign o_slv_pprot  = i_root_pprot;

  apb0_slv_mux #(.SLV_NUM(SLV_NUM)) u_mux (
    .idx          (idx),
    .hit          (hit),
    .tout_flag    (tout_flag),
    .psel         (i_root_psel),
    .penable      (i_root_penable),
    .slv_pready   (i_slv_pready),
    .slv_pslverr  (i_slv_pslverr),
    .slv_prdata   (i_slv_prdata),
    .slv_psel     (o_slv_psel),
    .slv_penable  (o_slv_penable),
    .sel_pready   (sel_pready),
    .root_pready  (o_root_pready),
    .root_pslverr (o_root_pslverr),
    .root_prdata  (o_root_prdata)
  );

  // cnt_inc is the number of stalled access cycles including the current
  // one; the watchdog fires when that number reaches TIMEOUT, so a slave
  // raising pready on that very cycle still completes normally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (state_q == WD_IDLE) begin
      cnt_inc = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + 1'b1;
    end

    case (state_q)
      WD_IDLE: begin
        if ((TIMEOUT != 0) && i_pclk_en && i_root_psel && i_root_penable &&
            hit && !sel_pready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            fire    = 1'b1;
            state_d = WD_TOUT;
          end else begin
            state_d = WD_ACCESS;
          end
        end
      end
      WD_ACCESS: begin
        if (!i_root_psel) begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end else if (i_pclk_en) begin
          if (sel_pready) begin
            state_d = WD_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              fire    = 1'b1;
              state_d = WD_TOUT;
            end
          end
        end
      end
      WD_TOUT: begin
        // Leave once the bridge has finished the aborted transfer: either
        // idle (psel low) or the SETUP cycle of a back-to-back transfer.
        if (!i_root_psel || !i_root_penable) begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hrst_n) begin
    if (!i_hrst_n) begin
      state_q      <= WD_IDLE;
      cnt_q        <= '0;
      o_tout_pulse <= 1'b0;
      o_tout_idx   <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_tout_pulse <= fire;
      if (fire) begin
        o_tout_idx <= idx;
      end
    end
  end

endmodule
